// File: rtl/truth_table_scanner.sv
// truth_table_scanner: walks a small combinational block through every input
// combination, captures its response as a minterm mask and grades that mask
// against a golden truth table (pass/fail, mismatch count, first bad index).
module truth_table_scanner #(
  parameter int                     N_IN     = 4,
  parameter int                     SETTLE   = 1,
  parameter logic [(1<<N_IN)-1:0]   EXPECTED = 16'hFB8B
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [N_IN-1:0]        x_out,
  input  logic                   f_in,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   mask,
  output logic                   pass,
  output logic                   fail,
  output logic [N_IN:0]          mismatch_count,
  output logic [N_IN-1:0]        first_fail_idx
);

  localparam int NV = 1 << N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NV - 1);
  localparam logic [CW-1:0]   RELOAD   = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_IN-1:0]   x_q, x_d;
  logic [NV-1:0]     mask_q, mask_d;
  logic [N_IN:0]     mcnt_q, mcnt_d;
  logic [N_IN-1:0]   ffi_q, ffi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;

  // Next-state logic: the vector index lives in x_q itself, so the stimulus
  // register doubles as the scan position and never needs a separate counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    mask_d  = mask_q;
    mcnt_d  = mcnt_q;
    ffi_d   = ffi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;

    unique case (state_q)
      S_IDLE: begin
        x_d = '0;
        if (start) begin
          mask_d  = '0;
          mcnt_d  = '0;
          ffi_d   = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          cnt_d   = RELOAD;
          busy_d  = 1'b1;
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_SAMPLE: begin
        mask_d[x_q] = f_in;
        if (f_in != EXPECTED[x_q]) begin
          mcnt_d = mcnt_q + 1'b1;
          if (mcnt_q == '0) begin
            ffi_d = x_q;
          end
        end
        if (x_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          x_d     = x_q + 1'b1;
          cnt_d   = RELOAD;
          state_d = S_SETTLE;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        pass_d  = (mcnt_q == '0);
        fail_d  = (mcnt_q != '0);
        busy_d  = 1'b0;
        x_d     = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any scan without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      mask_q  <= '0;
      mcnt_q  <= '0;
      ffi_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      mask_q  <= mask_d;
      mcnt_q  <= mcnt_d;
      ffi_q   <= ffi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign x_out          = x_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign mask           = mask_q;
  assign pass           = pass_q;
  assign fail           = fail_q;
  assign mismatch_count = mcnt_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: scoreboard bench. Stimulus pushes the hand-computed
// result of each scan into a queue; a monitor pops and grades on every done.
module tb_truth_table_scanner;

  typedef struct {
    logic [15:0] mask;
    logic        pass;
    logic        fail;
    logic [4:0]  mcnt;
    logic [3:0]  ffi;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic        startA, startB;
  logic        fA, fB;
  logic [3:0]  xA, xB;
  logic        busyA, busyB, doneA, doneB, passA, passB, failA, failB;
  logic [15:0] maskA, maskB;
  logic [4:0]  mcntA, mcntB;
  logic [3:0]  ffiA, ffiB;

  int   modeA;
  int   cyc;
  int   acceptA, acceptB;
  int   checks;
  int   errors;
  exp_t qA[$];
  exp_t qB[$];
  exp_t eA, eB;

  truth_table_scanner uA (
    .clk(clk), .rst_n(rst_n), .start(startA), .x_out(xA), .f_in(fA),
    .busy(busyA), .done(doneA), .mask(maskA), .pass(passA), .fail(failA),
    .mismatch_count(mcntA), .first_fail_idx(ffiA)
  );

  truth_table_scanner #(.N_IN(4), .SETTLE(3), .EXPECTED(16'hFB8B)) uB (
    .clk(clk), .rst_n(rst_n), .start(startB), .x_out(xB), .f_in(fB),
    .busy(busyB), .done(doneB), .mask(maskB), .pass(passB), .fail(failB),
    .mismatch_count(mcntB), .first_fail_idx(ffiB)
  );

  // System function F = X1X2 + X3X4 + (X1+~X2)(X4+~X3), X1 is the MSB
  function automatic logic sysF(input logic [3:0] x);
    logic x1, x2, x3, x4;
    x1 = x[3]; x2 = x[2]; x3 = x[1]; x4 = x[0];
    return (x1 & x2) | (x3 & x4) | ((x1 | ~x2) & (x4 | ~x3));
  endfunction

  assign fA = (modeA == 0) ? sysF(xA) : (modeA == 1) ? 1'b0 : ~sysF(xA);
  assign fB = sysF(xB);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Grade scanner A whenever it raises done
  always @(negedge clk) begin
    if (rst_n && doneA) begin
      if (qA.size() == 0) begin
        checkOutput("A_unexpected_done", 1, 0);
      end else begin
        eA = qA.pop_front();
        checkOutput("A_mask", maskA, eA.mask);
        checkOutput("A_pass", passA, eA.pass);
        checkOutput("A_fail", failA, eA.fail);
        checkOutput("A_mismatch_count", mcntA, eA.mcnt);
        checkOutput("A_first_fail_idx", ffiA, eA.ffi);
        checkOutput("A_done_latency", cyc - acceptA, eA.lat);
        checkOutput("A_busy_at_done", busyA, 0);
      end
    end
  end

  // Grade scanner B whenever it raises done
  always @(negedge clk) begin
    if (rst_n && doneB) begin
      if (qB.size() == 0) begin
        checkOutput("B_unexpected_done", 1, 0);
      end else begin
        eB = qB.pop_front();
        checkOutput("B_mask", maskB, eB.mask);
        checkOutput("B_pass", passB, eB.pass);
        checkOutput("B_fail", failB, eB.fail);
        checkOutput("B_mismatch_count", mcntB, eB.mcnt);
        checkOutput("B_first_fail_idx", ffiB, eB.ffi);
        checkOutput("B_done_latency", cyc - acceptB, eB.lat);
        checkOutput("B_busy_at_done", busyB, 0);
      end
    end
  end

  // Push the expected result, then hold start across one rising edge
  task automatic applyStimulus(input int sel, input int mode, input exp_t e);
    if (sel == 0) begin
      modeA = mode;
      qA.push_back(e);
      startA = 1'b1;
      @(posedge clk);
      #1 startA = 1'b0;
      acceptA = cyc;
      checkOutput("A_busy_after_start", busyA, 1);
    end else begin
      qB.push_back(e);
      startB = 1'b1;
      @(posedge clk);
      #1 startB = 1'b0;
      acceptB = cyc;
      checkOutput("B_busy_after_start", busyB, 1);
    end
  endtask

  task automatic pulseStartA();
    @(negedge clk);
    startA = 1'b1;
    @(posedge clk);
    #1 startA = 1'b0;
  endtask

  task automatic waitDrain(input int sel, input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      #1;
      if (sel == 0 && qA.size() == 0) return;
      if (sel == 1 && qB.size() == 0) return;
    end
    if (sel == 0) begin
      checkOutput("A_done_timeout", qA.size(), 0);
      qA.delete();
    end else begin
      checkOutput("B_done_timeout", qB.size(), 0);
      qB.delete();
    end
  endtask

  // Each vector of B is held SETTLE+1 = 4 cycles, counting 0..15
  task automatic checkXSequenceB();
    for (int v = 0; v < 16; v++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        checkOutput($sformatf("B_x_out_v%0d_k%0d", v, k), xB, v);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    modeA   = 0;
    acceptA = 0;
    acceptB = 0;
    startA  = 1'b0;
    startB  = 1'b0;
    rst_n   = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("A_reset_outputs", {xA, busyA, doneA, maskA, passA, failA, mcntA, ffiA}, 0);
    checkOutput("B_reset_outputs", {xB, busyB, doneB, maskB, passB, failB, mcntB, ffiB}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] scan with correct System model");
    applyStimulus(0, 0, '{16'hFB8B, 1'b1, 1'b0, 5'd0, 4'd0, 33});
    waitDrain(0, 100);
    @(negedge clk);
    checkOutput("A_x_out_idle", xA, 0);
    checkOutput("A_pass_held", passA, 1);

    $display("[TB] scan with f_in tied low");
    applyStimulus(0, 1, '{16'h0000, 1'b0, 1'b1, 5'd11, 4'd0, 33});
    waitDrain(0, 100);

    $display("[TB] scan with inverted model");
    applyStimulus(0, 2, '{16'h0474, 1'b0, 1'b1, 5'd16, 4'd0, 33});
    waitDrain(0, 100);

    $display("[TB] SETTLE=3 scan");
    applyStimulus(1, 0, '{16'hFB8B, 1'b1, 1'b0, 5'd0, 4'd0, 65});
    checkXSequenceB();
    waitDrain(1, 100);

    $display("[TB] start re-pulsed while busy");
    applyStimulus(0, 0, '{16'hFB8B, 1'b1, 1'b0, 5'd0, 4'd0, 33});
    repeat (3) @(negedge clk);
    pulseStartA();
    repeat (13) @(negedge clk);
    pulseStartA();
    waitDrain(0, 100);
    applyStimulus(0, 1, '{16'h0000, 1'b0, 1'b1, 5'd11, 4'd0, 33});
    checkOutput("A_results_cleared", {maskA, passA, failA, mcntA, ffiA}, 0);
    waitDrain(0, 100);

    $display("[TB] reset mid-scan");
    applyStimulus(0, 0, '{16'hFB8B, 1'b1, 1'b0, 5'd0, 4'd0, 33});
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("A_midscan_reset", {xA, busyA, doneA, maskA, passA, failA, mcntA, ffiA}, 0);
    qA.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("A_idle_after_reset", {busyA, maskA}, 0);
    applyStimulus(0, 0, '{16'hFB8B, 1'b1, 1'b0, 5'd0, 4'd0, 33});
    waitDrain(0, 100);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential driver/reader for small combinational blocks in the logic-circuit library; the default target is the 4-input System function.
- Steps the DUT inputs through all 2^N_IN combinations, waits a settle time, samples the DUT output and builds a minterm mask.
- Compares the mask against a golden truth table; reports pass/fail, mismatch count and first failing index.
- Replaces hand-written $monitor sweeps with a reusable, self-checking on-chip harness.

Parameters:
- N_IN, 4, number of DUT inputs; vector count = 2^N_IN (N_IN 1..6).
- SETTLE, 1, cycles each vector is held before sampling (>=1).
- EXPECTED, 16'hFB8B, golden mask, width 2^N_IN; bit i = expected F for input index i. Default is F = X1X2 + X3X4 + (X1+~X2)(X4+~X3).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin scan; sampled only in IDLE.
- x_out  output  N_IN  DUT stimulus; bit N_IN-1 = X1 (MSB), bit 0 = X4.
- f_in  input  1  DUT output; combinational from x_out.
- busy  output  1  high from the cycle after start is accepted until DONE exits.
- done  output  1  one-cycle pulse when results are valid.
- mask  output  2^N_IN  captured truth table; bit i = f_in sampled at x_out = i.
- pass  output  1  mask == EXPECTED; valid from done, held.
- fail  output  1  ~pass once a scan completes; 0 after reset/start.
- mismatch_count  output  N_IN+1  number of bits where mask differs from EXPECTED.
- first_fail_idx  output  N_IN  lowest mismatching index; 0 if none.

Behaviour:
- Reset (async, rst_n=0): state IDLE; x_out, mask, mismatch_count, first_fail_idx = 0; busy, done, pass, fail = 0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> idx=0, x_out=0.
  - Clear mask, mismatch_count, first_fail_idx, pass, fail.
  - Load settle counter with SETTLE-1; go to SETTLE.
- SETTLE: hold x_out; decrement the counter; at 0, go to SAMPLE.
- SAMPLE (1 cycle):
  - mask[idx] <= f_in.
  - If f_in != EXPECTED[idx]: mismatch_count += 1. If this is the first mismatch, first_fail_idx <= idx.
  - If idx == 2^N_IN-1, go to DONE. Otherwise idx+1 -> x_out, reload the counter, go to SETTLE.
- DONE (1 cycle):
  - done=1; pass <= (mismatch_count==0); fail <= ~that.
  - busy=0 next cycle; return to IDLE.
- Timing:
  - Each vector takes SETTLE+1 cycles.
  - done is high exactly 2^N_IN*(SETTLE+1)+1 cycles after the start-accept edge (default: 33).
- Result hold: x_out returns to 0 in IDLE. mask, pass, fail, mismatch_count and first_fail_idx hold until the next accepted start.
- start while busy, or in the DONE cycle: ignored, with no effect on the running scan.
- start held high continuously: a new scan begins on the first IDLE cycle after DONE.
- Index wrap: idx never wraps; the final vector is index 2^N_IN-1.
- Counter width: mismatch_count is N_IN+1 bits, so an all-bits mismatch (2^N_IN) does not overflow.
- Reset mid-scan: immediate return to reset values; no partial done; a new start is required.
- f_in is sampled only in SAMPLE; glitches during SETTLE are don't-care.

Test Plan:
- Defaults; f_in driven by the System function model; start pulse -> done at cycle 33, mask=16'hFB8B, pass=1, fail=0, mismatch_count=0, first_fail_idx=0.
- f_in tied 0 -> mask=16'h0000, mismatch_count=11, first_fail_idx=0, fail=1.
- f_in = inverted System model -> mask=16'h0474, mismatch_count=16, first_fail_idx=0, pass=0.
- SETTLE=3, correct model -> done at cycle 65. The x_out sequence is 0..15, each value held 4 cycles. mask=16'hFB8B.
- start re-pulsed at cycles 5 and 20 of a scan -> no restart, done still at cycle 33. A start on the cycle after done begins a fresh scan, and results clear.
- rst_n low at cycle 12 mid-scan -> all outputs 0 the same cycle, no done pulse. The next start gives a complete scan with mask=16'hFB8B.
